// File: rtl/frame_descrambler_checker_if.sv
// Byte-stream bundle for the frame descrambler/checker.
// Input stream, payload output stream and frame status.
interface frame_descrambler_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       stat_valid;
  logic       stat_crc_ok;
  logic       stat_runt;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  stat_valid,
    input  stat_crc_ok,
    input  stat_runt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output stat_valid,
    output stat_crc_ok,
    output stat_runt
  );
endinterface

// File: rtl/frame_descrambler_checker.sv
// Self-synchronizing x^58+x^39+1 descrambler with CRC-32 check.
// Holds back the last 4 bytes of each frame so the FCS is stripped.
module frame_descrambler_checker #(
  parameter logic [31:0] CRC_INIT    = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3
) (
  input  logic clk,
  input  logic rst,
  input  logic descr_en,
  frame_descrambler_checker_if.slave bus
);

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      if (r[0])
        r = (r >> 1) ^ 32'hEDB8_8320;
      else
        r = r >> 1;
    end
    return r;
  endfunction

  logic [57:0] scr_q;
  logic [57:0] scr_d;
  logic [7:0]  dsc_byte;
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;
  logic [2:0]  fill_q;
  logic [7:0]  fifo_q [4];
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        out_last_q;
  logic        stat_valid_q;
  logic        stat_ok_q;
  logic        stat_runt_q;

  logic full;
  logic accept;
  logic pop;
  logic frame_end;
  logic shift_out;

  assign full      = (fill_q == 3'd4);
  assign pop       = out_valid_q && bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;
  assign frame_end = accept && bus.in_last;
  assign shift_out = accept && full;

  assign bus.in_ready    = !full || !out_valid_q || bus.out_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.stat_valid  = stat_valid_q;
  assign bus.stat_crc_ok = stat_ok_q;
  assign bus.stat_runt   = stat_runt_q;

  // Descramble one byte LSB first; history holds received bits.
  always_comb begin
    scr_d    = scr_q;
    dsc_byte = '0;
    for (int i = 0; i < 8; i++) begin
      dsc_byte[i] = bus.in_data[i]
                  ^ (descr_en & (scr_d[38] ^ scr_d[57]));
      scr_d = {scr_d[56:0], bus.in_data[i]};
    end
  end

  assign crc_nxt = crc_byte(crc_q, dsc_byte);

  // Descrambler history; never cleared between frames.
  always_ff @(posedge clk) begin
    if (rst)
      scr_q <= '0;
    else if (accept)
      scr_q <= scr_d;
  end

  // CRC register; reloads after the final FCS byte.
  always_ff @(posedge clk) begin
    if (rst)
      crc_q <= CRC_INIT;
    else if (accept)
      crc_q <= bus.in_last ? CRC_INIT : crc_nxt;
  end

  // Strip buffer occupancy, restarted at every frame end.
  always_ff @(posedge clk) begin
    if (rst)
      fill_q <= '0;
    else if (accept) begin
      if (bus.in_last)
        fill_q <= '0;
      else if (!full)
        fill_q <= fill_q + 3'd1;
    end
  end

  // Strip buffer contents, oldest byte in slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        fifo_q[i] <= '0;
    end else if (accept) begin
      if (full) begin
        fifo_q[0] <= fifo_q[1];
        fifo_q[1] <= fifo_q[2];
        fifo_q[2] <= fifo_q[3];
        fifo_q[3] <= dsc_byte;
      end else begin
        fifo_q[fill_q[1:0]] <= dsc_byte;
      end
    end
  end

  // Output register; reloads in the cycle it is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (shift_out) begin
      out_valid_q <= 1'b1;
      out_data_q  <= fifo_q[0];
      out_last_q  <= bus.in_last;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  // One-cycle status pulse after the last FCS byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_valid_q <= 1'b0;
      stat_ok_q    <= 1'b0;
      stat_runt_q  <= 1'b0;
    end else begin
      stat_valid_q <= frame_end;
      stat_runt_q  <= frame_end && !full;
      stat_ok_q    <= frame_end && full
                   && (crc_nxt == CRC_RESIDUE);
    end
  end

endmodule

// File: tb/tb_frame_descrambler_checker.sv
// Directed frame table plus reset and backpressure sequences.
// A cycle model predicts handshake, payload and status.
module tb_frame_descrambler_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic descr_en = 1'b0;
  bit   bp = 1'b0;

  frame_descrambler_checker_if bus();

  frame_descrambler_checker dut (
    .clk      (clk),
    .rst      (rst),
    .descr_en (descr_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d [0:15];
    int         len;
    bit         en;
    bit         scr;
    bit         chk;
    bit         ok;
    int         flip;
  } frame_t;

  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         chk;
  } exp_t;

  typedef struct {
    bit ok;
    bit runt;
    bit chk;
  } st_t;

  frame_t tbl [10];
  exp_t   exp_q [$];
  st_t    st_q  [$];

  int total  = 0;
  int passes = 0;

  logic [57:0] sc = 58'h2AB_CD13_579B_DF02;

  int m_fill = 0;
  bit m_ov   = 0;
  bit m_stat = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
  endtask

  function automatic logic [7:0] scramble(input logic [7:0] p);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      c[i] = p[i] ^ sc[38] ^ sc[57];
      sc = {sc[56:0], c[i]};
    end
    return c;
  endfunction

  task automatic mk(int i, string txt, bit fcs,
                    logic [31:0] crc, bit en, bit scr,
                    bit chk_en, bit ok, int flip);
    tbl[i].len = txt.len();
    for (int k = 0; k < txt.len(); k++)
      tbl[i].d[k] = txt[k];
    if (fcs) begin
      for (int j = 0; j < 4; j++)
        tbl[i].d[tbl[i].len + j] = crc[8*j +: 8];
      tbl[i].len += 4;
    end
    tbl[i].en   = en;
    tbl[i].scr  = scr;
    tbl[i].chk  = chk_en;
    tbl[i].ok   = ok;
    tbl[i].flip = flip;
  endtask

  task automatic send_frame(int i, int stop_after);
    int n;
    logic [7:0] b;
    bit got;
    n = tbl[i].len;
    descr_en = tbl[i].en;
    for (int k = 0; k < n - 4; k++) begin
      b = tbl[i].d[k];
      if (k == tbl[i].flip) b[0] = ~b[0];
      exp_q.push_back('{d: b, last: (k == n - 5),
                        chk: tbl[i].chk});
    end
    st_q.push_back('{ok: tbl[i].ok, runt: (n < 5),
                     chk: tbl[i].chk});
    for (int k = 0; k < n && k < stop_after; k++) begin
      b = tbl[i].d[k];
      if (k == tbl[i].flip) b[0] = ~b[0];
      if (tbl[i].scr) b = scramble(b);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.in_last  = (k == n - 1);
      got = 0;
      for (int c = 0; c < 1000 && !got; c++) begin
        @(negedge clk);
        got = bus.in_ready;
        @(posedge clk);
        #1;
      end
      if (!got) chk("accept_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && (exp_q.size() != 0
         || st_q.size() != 0); c++)
      @(posedge clk);
    chk("drain", exp_q.size() + st_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_in_ready"},  bus.in_ready,    1);
    chk({tag, "_out_valid"}, bus.out_valid,   0);
    chk({tag, "_out_data"},  bus.out_data,    0);
    chk({tag, "_out_last"},  bus.out_last,    0);
    chk({tag, "_stat_v"},    bus.stat_valid,  0);
    chk({tag, "_stat_ok"},   bus.stat_crc_ok, 0);
    chk({tag, "_stat_runt"}, bus.stat_runt,   0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp ? ($urandom_range(0, 99) < 30)
                         : 1'b1;
    end
  end

  initial begin
    bit exp_rdy;
    bit acc;
    bit pop;
    exp_t h;
    st_t  s;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_fill = 0;
        m_ov   = 0;
        m_stat = 0;
        exp_q.delete();
        st_q.delete();
      end else begin
        exp_rdy = (m_fill < 4) || !m_ov || bus.out_ready;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, m_ov);
        if (m_ov) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            h = exp_q[0];
            chk("out_last", bus.out_last, h.last);
            if (h.chk) chk("out_data", bus.out_data, h.d);
          end
        end
        chk("stat_valid", bus.stat_valid, m_stat);
        if (m_stat) begin
          if (st_q.size() == 0) begin
            chk("unexpected_stat", 1, 0);
          end else begin
            s = st_q.pop_front();
            chk("stat_runt", bus.stat_runt, s.runt);
            if (s.chk) chk("stat_crc_ok", bus.stat_crc_ok, s.ok);
          end
        end
        acc = bus.in_valid && exp_rdy;
        pop = m_ov && bus.out_ready;
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc && m_fill == 4) m_ov = 1;
        else if (pop) m_ov = 0;
        m_stat = acc && bus.in_last;
        if (acc) begin
          if (bus.in_last) m_fill = 0;
          else if (m_fill < 4) m_fill = m_fill + 1;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 5, 2, 1, 0};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    mk(0, "123456789", 1, 32'hCBF4_3926, 0, 0, 1, 1, -1);
    mk(1, "123456789", 1, 32'hCBF4_3926, 0, 0, 1, 0, 3);
    mk(2, "123456789", 1, 32'hCBF4_3926, 0, 0, 1, 1, -1);
    mk(3, "xyz",       0, 32'h0,         0, 0, 1, 0, -1);
    mk(4, "",          1, 32'h0,         0, 0, 1, 0, -1);
    mk(5, "a",         1, 32'hE8B7_BE43, 0, 0, 1, 1, -1);
    mk(6, "Q7#kz!Lp",  0, 32'h0,         1, 0, 0, 0, -1);
    mk(7, "123456789", 1, 32'hCBF4_3926, 1, 1, 0, 1, -1);
    mk(8, "abc",       1, 32'h3524_41C2, 1, 1, 1, 1, -1);
    mk(9, "123456789", 1, 32'hCBF4_3926, 1, 1, 1, 1, -1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("rst0");
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) send_frame(i, 99);
    drain();

    for (int i = 6; i < 10; i++) send_frame(i, 99);
    drain();

    bp = 1'b1;
    foreach (order[i]) send_frame(order[i], 99);
    drain();
    bp = 1'b0;
    @(posedge clk);
    #1;

    send_frame(0, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    @(posedge clk);
    #1;
    send_frame(0, 99);
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
